// File: rtl/tanh_grad_calc_if.sv
// Streaming handshake bundle for the tanh backward-pass block.
// The slave modport is the block's view. The master modport is the view of
// whatever drives samples in and takes results out.
interface tanh_grad_calc_if;
  logic [7:0] in_y;
  logic [7:0] in_g;
  logic       in_last;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_d;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;

  modport slave (
    input  in_y, in_g, in_last, in_valid, out_ready,
    output in_ready, out_d, out_last, out_valid
  );

  modport master (
    output in_y, in_g, in_last, in_valid, out_ready,
    input  in_ready, out_d, out_last, out_valid
  );
endinterface

// File: rtl/tanh_grad_calc.sv
// Local tanh gradient g * (1 - y^2).
// y is Q1.7, g is Q2.6 and the result is Q2.6.
// Two-stage valid/ready pipeline with full backpressure:
//   stage 1 forms d = 1 - y^2 (Q1.7, 9 bits, 0..128)
//   stage 2 forms floor(g * d / 128)
// No saturation is needed, because |d| <= 1.0 keeps the product inside the Q2.6 range.
module tanh_grad_calc #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  tanh_grad_calc_if.slave  bus,
  output logic [CNT_W-1:0] sample_cnt
);

  logic              r_s1_valid;
  logic [8:0]        r_s1_d;
  logic [7:0]        r_s1_g;
  logic              r_s1_last;
  logic              r_s2_valid;
  logic [7:0]        r_s2_d;
  logic              r_s2_last;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_s2_adv;
  logic              w_s1_adv;
  logic signed [15:0] w_y_ext;
  logic [8:0]        w_d;
  logic signed [17:0] w_g_ext;
  logic signed [17:0] w_d_ext;
  logic [7:0]        w_prod_q;

  // Pipeline advance terms. in_ready depends only on state and out_ready.
  always_comb begin
    w_s2_adv = ~r_s2_valid | bus.out_ready;
    w_s1_adv = ~r_s1_valid | w_s2_adv;
  end

  // Stage-1 arithmetic: y^2 is never negative, so a logical shift is enough.
  always_comb begin
    w_y_ext = {{8{bus.in_y[7]}}, bus.in_y};
    w_d     = 9'd128 - 9'((w_y_ext * w_y_ext) >> 7);
  end

  // Stage-2 arithmetic: signed g times unsigned d, then an arithmetic shift (floor).
  always_comb begin
    w_g_ext  = {{10{r_s1_g[7]}}, r_s1_g};
    w_d_ext  = {9'd0, r_s1_d};
    w_prod_q = 8'((w_g_ext * w_d_ext) >>> 7);
  end

  // Stage 1 register: loads whenever it is empty or draining into stage 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_d     <= '0;
      r_s1_g     <= '0;
      r_s1_last  <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= bus.in_valid;
      r_s1_d     <= w_d;
      r_s1_g     <= bus.in_g;
      r_s1_last  <= bus.in_last;
    end
  end

  // Stage 2 (output) register: holds its contents while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_d     <= '0;
      r_s2_last  <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_d     <= w_prod_q;
      r_s2_last  <= r_s1_last;
    end
  end

  // Delivered-sample counter. It wraps modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_s2_valid && bus.out_ready) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = w_s1_adv;
  assign bus.out_d     = r_s2_d;
  assign bus.out_last  = r_s2_last;
  assign bus.out_valid = r_s2_valid;
  assign sample_cnt    = r_cnt;

endmodule

// File: tb/tb_tanh_grad_calc.sv
// Scoreboard bench for tanh_grad_calc.
// The driver pushes the expected result when a sample is accepted.
// The monitor pops and compares on every output transfer.
module tb_tanh_grad_calc;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sample_cnt;

  always #5 clk = ~clk;

  tanh_grad_calc_if bus ();

  tanh_grad_calc #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sample_cnt (sample_cnt)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_delivered = 0;
  bit   rnd_on = 1'b0;

  // Reference model: d = 1 - y^2 in 1/128 units, result = floor(g * d / 128).
  function automatic logic [7:0] ref_model(logic [7:0] y, logic [7:0] g);
    int yi, gi, d, p, q;
    yi = $signed(y);
    gi = $signed(g);
    d  = 128 - (yi * yi) / 128;
    p  = gi * d;
    q  = p / 128;
    if (p < 0 && (p % 128) != 0) q = q - 1;
    return 8'(q);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every output transfer against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got out_d=%0h with no sample outstanding", bus.out_d);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_d", {24'd0, bus.out_d}, {24'd0, e.d});
        check("out_last", {31'd0, bus.out_last}, {31'd0, e.last});
      end
      n_delivered++;
    end
  end

  // Present one sample and hold it until it is accepted. The task returns just after the accept edge.
  task automatic send(logic [7:0] y, logic [7:0] g, logic last, bit use_exp, logic [7:0] exp_d);
    bit done;
    exp_t e;
    done = 1'b0;
    bus.in_y     = y;
    bus.in_g     = g;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.d    = use_exp ? exp_d : ref_model(y, g);
        e.last = last;
        sb.push_back(e);
        done   = 1'b1;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for 1000 cycles expected 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Single sample with out_ready=1: the result must appear exactly two edges after it was presented.
  task automatic lat_test(logic [7:0] y, logic [7:0] g, logic [7:0] exp_d);
    exp_t e;
    bus.in_y     = y;
    bus.in_g     = g;
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("lat_in_ready", {31'd0, bus.in_ready}, 32'd1);
    e.d    = exp_d;
    e.last = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("lat_valid_cycle1", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    check("lat_valid_cycle2", {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic wait_drain(string name, int exp_cnt);
    for (int k = 0; k < 500 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_drain: got %0d samples outstanding expected 0", name, sb.size());
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    check(name, {16'd0, sample_cnt}, exp_cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    n_delivered = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation time limit expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
    rst           = 1'b1;
    bus.in_y      = '0;
    bus.in_g      = '0;
    bus.in_last   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset and idle state
    @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_sample_cnt", {16'd0, sample_cnt}, 32'd0);
    check("rst_out_d", {24'd0, bus.out_d}, 32'd0);

    // Single sample: 0.5 and 1.0 give 0.75
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    lat_test(8'h40, 8'h40, 8'h30);
    wait_drain("cnt_single", 1);

    // Corner values
    @(posedge clk);
    #1;
    send(8'h00, 8'h80, 1'b0, 1'b1, 8'h80);
    send(8'h80, 8'h7F, 1'b0, 1'b1, 8'h00);
    send(8'h7F, 8'h80, 1'b0, 1'b1, 8'hFE);
    send(8'h40, 8'hFF, 1'b1, 1'b1, 8'hFF);
    wait_drain("cnt_corners", 5);

    // Back-to-back burst of 8 with a 4-cycle downstream stall
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(8'($urandom), 8'($urandom), (i == 7), 1'b0, 8'h00);
      end
      begin
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        held = bus.out_d;
        check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        repeat (3) begin
          @(negedge clk);
          check("stall_out_d_stable", {24'd0, bus.out_d}, {24'd0, held});
          check("stall_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain("cnt_burst", 13);

    // Reset with two samples in flight
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b0, 1'b0, 8'h00);
    send(8'h33, 8'h44, 1'b1, 1'b0, 8'h00);
    do_reset();
    @(negedge clk);
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_sample_cnt", {16'd0, sample_cnt}, 32'd0);
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    lat_test(8'h20, 8'hC0, ref_model(8'h20, 8'hC0));
    repeat (4) @(negedge clk);
    wait_drain("midrst_cnt_after", 1);

    // Random traffic: 1000 samples with random valid gaps and random out_ready
    do_reset();
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 1) == 1) begin
            @(posedge clk);
            #1;
          end
          send(8'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0), 1'b0, 8'h00);
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_drain("rand_sample_cnt", 1000);
    check("rand_delivered", n_delivered, 32'd1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
